mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the word-wide on-chip RAM.
- Accepts byte/half/word requests from the core over a valid/ready handshake and drives the RAM port (ce/we/addr/wdata, combinational rdata).
- Sub-word stores are done as read-modify-write, because the RAM only writes whole words.
- Returns sign- or zero-extended load data, plus an error flag for misaligned or out-of-range accesses.
- Byte order is big-endian: byte offset 0 = bits [31:24].

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- MEM_SIZE, 1024, RAM size in bytes; any address >= MEM_SIZE is out of range.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  synchronous reset, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept request
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_rdata_o  out  XLEN  load result; 0 for stores and errors
- rsp_err_o  out  1  misaligned/illegal size/out of range
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- ram_wdata_o  out  XLEN  RAM write word
- ram_rdata_i  in  XLEN  RAM combinational read word

Behaviour:
- Reset (rst_ni=0 at an edge):
  - State goes to IDLE.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Latched request registers are cleared to 0.
- RAM gating: ram_ce_o and ram_we_o are ANDed with rst_ni combinationally, so no RAM access or write occurs in any cycle where rst_ni=0, including mid read-modify-write.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready_o=1 and ram_ce_o=0; req_ready_o is 0 in every other state.
  - On req_valid_i, latch addr/size/we/unsigned/wdata and check for errors.
  - Error conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr > MEM_SIZE-1.
  - Error -> RESP with err=1, rdata=0, no RAM access.
  - Otherwise: load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
- LOAD: ce=1, we=0. Extract the lane from ram_rdata_i, extend it, register it into rsp_rdata_o, then go to RESP.
  - byte k -> word[31-8k -: 8]
  - half offset 0 -> [31:16], offset 2 -> [15:0]
  - word -> unchanged
- WRITE: ce=1, we=1, wdata = latched wdata. Then RESP.
- RMW_RD: ce=1, we=0. Capture ram_rdata_i into a merge register, then RMW_WR.
- RMW_WR: ce=1, we=1, same address. wdata = merge register with the addressed lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged. Then RESP.
- RESP:
  - rsp_valid_o=1; rdata/err held stable until rsp_ready_i=1.
  - On handshake: next edge goes to IDLE and rsp_valid_o=0.
  - No new request is accepted in the same cycle as the handshake.
- Latency (accept edge = cycle 0), cycle in which rsp_valid_o first reads 1:
  - error: cycle 1
  - load / word store: cycle 2
  - sub-word store: cycle 3
- Exactly one RAM write per successful store; zero for loads and errors.
- ram_addr_o and ram_wdata_o are don't-care whenever ram_ce_o=0.
- Outside RESP: rsp_rdata_o and rsp_err_o are 0 (cleared on leaving RESP).

Test Plan:
- RAM[0x10]=0x80FF7F01; lb 0x11 -> 0xFFFFFFFF; lbu 0x11 -> 0x000000FF; lh 0x10 -> 0xFFFF80FF; lhu 0x12 -> 0x00007F01; lw 0x10 -> 0x80FF7F01, err=0, rsp_valid at cycle 2.
- RAM[0x20]=0x11223344; sb 0x22 data 0x000000AB -> RAM[0x20]=0x1122AB44; sh 0x20 data 0x0000BEEF -> 0xBEEFAB44; rsp at cycle 3; exactly one we pulse each.
- sw 0x30 0xDEADBEEF then lw 0x30 -> 0xDEADBEEF; rsp_rdata=0 on store response.
- lh 0x11, lw 0x12, size=11 at 0x0, lw 0x400 (MEM_SIZE=1024) -> err=1, rdata=0, rsp at cycle 1, ram_ce_o never 1.
- Hold rsp_ready_i=0 for 4 cycles after a load -> rsp_valid/rdata stable, req_ready_o=0; release -> IDLE next cycle, back-to-back request accepted.
- rst_ni=0 during RMW_RD and again during RMW_WR of sb to 0x20 -> no RAM write, RAM unchanged, all outputs 0, IDLE after reset.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Core-side request/response channel of the load/store unit.
// The core drives the master modport and the LSU takes the slave modport.
interface mem_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide RAM: big-endian byte lanes,
// read-modify-write for sub-word stores, sign/zero-extended loads.
module mem_lsu #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  mem_lsu_if.slave        core,
  output logic            ram_ce_o,
  output logic            ram_we_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  state_e          state_r;
  logic            req_ready_r;
  logic            rsp_valid_r;
  logic            rsp_err_r;
  logic [XLEN-1:0] rsp_rdata_r;
  logic            ram_ce_r;
  logic            ram_we_r;
  logic [XLEN-1:0] ram_wdata_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wdata_r;
  logic [1:0]      size_r;
  logic            we_r;
  logic            unsigned_r;
  logic            size_err_s;
  logic            req_err_s;

  // Offset 0 is the most significant byte of the word.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] offs,
                                                   input logic uns);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (offs)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = offs[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] word,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [1:0] size,
                                                  input logic [1:0] offs);
    logic [XLEN-1:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (offs)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (offs[1]) begin
          r[15:0] = wdata[15:0];
        end else begin
          r[31:16] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Alignment and size legality of the incoming request.
  always_comb begin
    size_err_s = 1'b0;
    case (core.req_size)
      2'b00:   size_err_s = 1'b0;
      2'b01:   size_err_s = core.req_addr[0];
      2'b10:   size_err_s = (core.req_addr[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
  end

  assign req_err_s = size_err_s | (core.req_addr >= MEM_LIMIT);

  // Request sequencing FSM with registered handshake and RAM controls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      ram_ce_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_wdata_r <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      size_r      <= 2'b00;
      we_r        <= 1'b0;
      unsigned_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (core.req_valid) begin
            addr_r      <= core.req_addr;
            wdata_r     <= core.req_wdata;
            size_r      <= core.req_size;
            we_r        <= core.req_we;
            unsigned_r  <= core.req_unsigned;
            req_ready_r <= 1'b0;
            ram_wdata_r <= core.req_wdata;
            if (req_err_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end else if (!core.req_we) begin
              state_r  <= LOAD;
              ram_ce_r <= 1'b1;
              ram_we_r <= 1'b0;
            end else if (core.req_size == 2'b10) begin
              state_r  <= WRITE;
              ram_ce_r <= 1'b1;
              ram_we_r <= 1'b1;
            end else begin
              state_r  <= RMW_RD;
              ram_ce_r <= 1'b1;
              ram_we_r <= 1'b0;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        LOAD: begin
          rsp_rdata_r <= load_extract(ram_rdata_i, size_r, addr_r[1:0], unsigned_r);
          rsp_valid_r <= 1'b1;
          ram_ce_r    <= 1'b0;
          state_r     <= RESP;
        end
        WRITE: begin
          ram_ce_r    <= 1'b0;
          ram_we_r    <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= '0;
          state_r     <= RESP;
        end
        RMW_RD: begin
          // The merged word is built here so the write cycle drives a register.
          ram_wdata_r <= store_merge(ram_rdata_i, wdata_r, size_r, addr_r[1:0]);
          ram_we_r    <= we_r;
          state_r     <= RMW_WR;
        end
        RMW_WR: begin
          ram_ce_r    <= 1'b0;
          ram_we_r    <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= '0;
          state_r     <= RESP;
        end
        RESP: begin
          if (core.rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
            req_ready_r <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
          ram_ce_r    <= 1'b0;
          ram_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign core.req_ready = req_ready_r;
  assign core.rsp_valid = rsp_valid_r;
  assign core.rsp_rdata = rsp_rdata_r;
  assign core.rsp_err   = rsp_err_r;

  // Reset masks the RAM strobes immediately, even mid read-modify-write.
  assign ram_ce_o    = ram_ce_r & rst_ni;
  assign ram_we_o    = ram_we_r & rst_ni;
  assign ram_addr_o  = {addr_r[XLEN-1:2], 2'b00};
  assign ram_wdata_o = ram_wdata_r;

endmodule
